// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//   UART transmitter with a frame format chosen per word: baud divisor,
//   parity (none / even / odd) and one or two stop bits. Words arrive over a
//   valid/ready handshake. A new frame starts only while CTS is asserted.
//   Busy and done status are reported. Sits between a TX FIFO or register
//   block and the uart_txd pad.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9), sent LSB first
//   DIV_WIDTH   width of the baud divisor input
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   tx_data_i   word to send
//   tx_valid_i  tx_data_i is valid
//   tx_ready_o  block can accept a word this cycle (IDLE and CTS clear)
//   div_i       clocks per bit; values below 2 are treated as 2
//   parity_i    0 none, 1 even, 2 odd, 3 reserved (treated as none)
//   stop2_i     1 = two stop bits, 0 = one stop bit
//   cts_n_i     asynchronous clear-to-send, active low
//   txd_o       serial line, driven straight from a flop, idles high
//   busy_o      frame in progress
//   done_o      one-cycle pulse when the final stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic [1:0]            parity_i,
    input  logic                  stop2_i,
    input  logic                  cts_n_i,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned            BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    // -------------------------------------------------------------------------
    // CTS synchroniser
    // -------------------------------------------------------------------------
    logic [1:0] cts_sync_q;
    logic       cts_ok;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the values that existed before the clock edge.
    // The synchroniser resets to "not clear" so nothing can start until a real
    // CTS level has crossed both flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n_i};
        end
    end

    assign cts_ok = ~cts_sync_q[1];

    // -------------------------------------------------------------------------
    // Frame state
    // -------------------------------------------------------------------------
    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic [DIV_WIDTH-1:0]   div_m1_q;      // clamped divisor minus one
    logic                   par_en_q;
    logic                   par_bit_q;
    logic                   stop2_q;
    logic                   stop_second_q; // currently sending the second stop bit
    logic                   txd_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   tick;

    // Per-frame configuration captured on the accept edge.
    logic [DIV_WIDTH-1:0]   div_m1_d;
    logic                   par_en_d;
    logic                   par_bit_d;

    // Ready looks only at registers, never at tx_valid_i, so upstream can
    // safely make valid depend on ready.
    assign tx_ready_o = (state_q == S_IDLE) && cts_ok;
    assign accept     = tx_valid_i && tx_ready_o;

    // Storing DIV-1 lets the end-of-bit compare run without a subtractor.
    assign tick = (cnt_q == div_m1_q);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        par_en_d  = 1'b0;
        par_bit_d = 1'b0;
        div_m1_d  = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : (div_i - DIV_WIDTH'(1));
        case (parity_e'(parity_i))
            PAR_EVEN: begin
                par_en_d  = 1'b1;
                par_bit_d = ^tx_data_i;
            end
            PAR_ODD: begin
                par_en_d  = 1'b1;
                par_bit_d = ~^tx_data_i;
            end
            default: begin
                // none and reserved both send no parity bit
                par_en_d  = 1'b0;
                par_bit_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            cnt_q         <= '0;
            div_m1_q      <= DIV_WIDTH'(1);
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            txd_q         <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                if (accept) begin
                    shift_q       <= tx_data_i;
                    div_m1_q      <= div_m1_d;
                    par_en_q      <= par_en_d;
                    par_bit_q     <= par_bit_d;
                    stop2_q       <= stop2_i;
                    stop_second_q <= 1'b0;
                    bit_cnt_q     <= '0;
                    state_q       <= S_START;
                    txd_q         <= 1'b0;
                    busy_q        <= 1'b1;
                end
            end else if (!tick) begin
                cnt_q <= cnt_q + DIV_WIDTH'(1);
            end else begin
                // End of the current bit period: move on to the next bit.
                cnt_q <= '0;
                case (state_q)
                    S_START: begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        txd_q     <= shift_q[0];
                    end
                    S_DATA: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            // Next data bit is the one above the bit just sent.
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            txd_q     <= shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                    end
                    S_STOP: begin
                        if (stop2_q && !stop_second_q) begin
                            stop_second_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                        txd_q <= 1'b1;
                    end
                    default: begin
                        // Unreachable encodings recover to a quiet idle line.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
